// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register file geometry and MDU latency.
package pipe_pkg;

    localparam int REG_W   = 5;
    localparam int NREGS   = 32;
    localparam int MDU_LAT = 4;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/sb_counter.sv
// Saturating down-counter used for one scoreboard entry.
// A load has priority over the decrement. The count stops at zero and never wraps.
module sb_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             nz_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise step toward zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register; reset abandons any countdown in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nz_o = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Producer-side hazard scoreboard for the 5-stage pipeline.
//
// The scoreboard tracks registers whose writer is a load or the MDU, until the
// result becomes forwardable. It raises stall in ID for RAW, WAW and MDU
// structural hazards.
//
// Optional macro SCOREBOARD_STATS_EN adds a saturating 32-bit stall_cycles counter.
//
// Handshake: an ID instruction issues when id_valid=1, id_flush=0 and stall=0.
// While stall is high, the pipeline holds the ID inputs stable.
// When id_flush is high, nothing issues and stall stays low.
module reg_scoreboard
    import pipe_pkg::*;
#(
    parameter int CNT_W = 4   // 2**CNT_W must exceed MDU_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  reg_idx_t         id_RegS,
    input  reg_idx_t         id_RegT,
    input  logic             id_useS,
    input  logic             id_useT,
    input  reg_idx_t         id_RegD,
    input  logic             id_RegWrite,
    input  logic             id_isLoad,
    input  logic             id_isMdu,
    input  logic             id_flush,
    output logic             stall,
    output logic             mdu_busy,
`ifdef SCOREBOARD_STATS_EN
    output logic [31:0]      stall_cycles,
`endif
    output logic [NREGS-1:0] pending
);

    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(1);
    localparam logic [CNT_W-1:0] MDU_CNT  = CNT_W'(MDU_LAT);

    logic raw_hit;
    logic waw_hit;
    logic struct_hit;
    logic issue;
    logic dst_track;
    logic [CNT_W-1:0] dst_val;

    // Hazard detection and issue decision. These depend only on registered
    // scoreboard state, so there is no combinational loop through stall.
    always_comb begin
        raw_hit    = (id_useS && pending[id_RegS]) || (id_useT && pending[id_RegT]);
        waw_hit    = id_RegWrite && (id_RegD != ZERO_REG) && pending[id_RegD];
        struct_hit = id_isMdu && mdu_busy;
        stall      = id_valid && !id_flush && (raw_hit || waw_hit || struct_hit);
        issue      = id_valid && !id_flush && !stall;
        // Only long-latency writers are tracked. ALU results are forwarded.
        dst_track  = issue && id_RegWrite && (id_RegD != ZERO_REG) && (id_isLoad || id_isMdu);
        // If both flags are set, the load path wins: one bubble only.
        dst_val    = id_isLoad ? LOAD_CNT : MDU_CNT;
    end

    // One countdown per architectural register. Register 0 is never tracked.
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign pending[r] = 1'b0;
        end else begin : g_cnt
            logic ld;
            assign ld = dst_track && (id_RegD == reg_idx_t'(r));
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk    (clk),
                .rst_n  (rst_n),
                .load_i (ld),
                .val_i  (dst_val),
                .nz_o   (pending[r])
            );
        end
    end

    // MDU occupancy. It is armed by any MDU issue, even one with no register write.
    sb_counter #(.CNT_W(CNT_W)) u_mdu_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (issue && id_isMdu),
        .val_i  (MDU_CNT),
        .nz_o   (mdu_busy)
    );

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q;

    // Count the cycles in which stall is asserted. The count saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard (MDU_LAT = 4).
// Optional macro SCOREBOARD_STATS_EN enables the stall_cycles checks.
module tb_reg_scoreboard;
    import pipe_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic     id_valid, id_useS, id_useT, id_RegWrite, id_isLoad, id_isMdu, id_flush;
    reg_idx_t id_RegS, id_RegT, id_RegD;
    logic     stall, mdu_busy;
    logic [NREGS-1:0] pending;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    reg_scoreboard #(.CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_RegS     (id_RegS),
        .id_RegT     (id_RegT),
        .id_useS     (id_useS),
        .id_useT     (id_useT),
        .id_RegD     (id_RegD),
        .id_RegWrite (id_RegWrite),
        .id_isLoad   (id_isLoad),
        .id_isMdu    (id_isMdu),
        .id_flush    (id_flush),
        .stall       (stall),
        .mdu_busy    (mdu_busy),
`ifdef SCOREBOARD_STATS_EN
        .stall_cycles(stall_cycles),
`endif
        .pending     (pending)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    int exp_stall_cnt = 0;
    logic last_exp_stall = 1'b0;
    logic [NREGS+1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input reg_idx_t s, input logic us,
                         input reg_idx_t t, input logic ut, input reg_idx_t d,
                         input logic rw, input logic ld, input logic md, input logic fl);
        id_valid = v; id_RegS = s; id_useS = us; id_RegT = t; id_useT = ut;
        id_RegD = d; id_RegWrite = rw; id_isLoad = ld; id_isMdu = md; id_flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Instruction that reads s and t and writes d through the ALU.
    task automatic alu(input reg_idx_t s, input reg_idx_t t, input reg_idx_t d, input logic fl);
        drive(1'b1, s, 1'b1, t, 1'b1, d, 1'b1, 1'b0, 1'b0, fl);
    endtask

    task automatic lw(input reg_idx_t base, input reg_idx_t d);
        drive(1'b1, base, 1'b1, 5'd0, 1'b0, d, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic mdu(input reg_idx_t s, input reg_idx_t t, input reg_idx_t d, input logic rw);
        drive(1'b1, s, 1'b1, t, 1'b1, d, rw, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic logic [NREGS-1:0] bit_of(input int r);
        logic [NREGS-1:0] b;
        b = '0;
        b[r] = 1'b1;
        return b;
    endfunction

    // Queue the expected outputs, let the combinational logic settle, then compare.
    task automatic expect_out(input string tag, input logic s, input logic b,
                              input logic [NREGS-1:0] p);
        logic [NREGS+1:0] obs;
        logic [NREGS+1:0] exp;
        exp_q.push_back({s, b, p});
        last_exp_stall = s;
        #1;
        obs = {stall, mdu_busy, pending};
        exp = exp_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed stall=%b busy=%b pending=%h, expected stall=%b busy=%b pending=%h",
                   tag, obs[NREGS+1], obs[NREGS], obs[NREGS-1:0],
                   exp[NREGS+1], exp[NREGS], exp[NREGS-1:0]);
        end
    endtask

    // Advance one clock. Inputs change only on the falling edge.
    task automatic tick();
        if (last_exp_stall) exp_stall_cnt++;
        last_exp_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle();
        @(negedge clk);
        expect_out("reset_state", 1'b0, 1'b0, '0);
        rst_n = 1'b1;
        tick();

        // Load-use: exactly one bubble.
        lw(5'd1, 5'd5);
        expect_out("lw_issue", 1'b0, 1'b0, '0);
        tick();
        alu(5'd5, 5'd7, 5'd6, 1'b0);
        expect_out("load_use_stall", 1'b1, 1'b0, bit_of(5));
        tick();
        expect_out("load_use_release", 1'b0, 1'b0, '0);
        tick();

        // MDU RAW: four stall cycles.
        mdu(5'd1, 5'd2, 5'd8, 1'b1);
        expect_out("mult_issue", 1'b0, 1'b0, '0);
        tick();
        alu(5'd8, 5'd0, 5'd10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("mdu_raw_stall%0d", i), 1'b1, 1'b1, bit_of(8));
            tick();
        end
        expect_out("mdu_raw_release", 1'b0, 1'b0, '0);
        tick();

        // Structural: a second MDU op waits for mdu_busy to clear.
        mdu(5'd1, 5'd2, 5'd11, 1'b1);
        expect_out("mdu1_issue", 1'b0, 1'b0, '0);
        tick();
        mdu(5'd3, 5'd4, 5'd12, 1'b1);
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("mdu_struct_stall%0d", i), 1'b1, 1'b1, bit_of(11));
            tick();
        end
        expect_out("mdu2_issue", 1'b0, 1'b0, '0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("mdu2_drain%0d", i), 1'b0, 1'b1, bit_of(12));
            tick();
        end
        expect_out("mdu2_done", 1'b0, 1'b0, '0);

        // An MDU op targeting r0 makes the unit busy but leaves r0 untracked.
        mdu(5'd1, 5'd2, 5'd0, 1'b1);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("mdu_r0_busy%0d", i), 1'b0, 1'b1, '0);
            tick();
        end
        expect_out("mdu_r0_done", 1'b0, 1'b0, '0);

        // Flush overrides a RAW hazard, and the countdown still decrements.
        lw(5'd1, 5'd5);
        tick();
        alu(5'd5, 5'd3, 5'd6, 1'b1);
        expect_out("flush_no_stall", 1'b0, 1'b0, bit_of(5));
        tick();
        alu(5'd5, 5'd3, 5'd6, 1'b0);
        expect_out("after_flush_clear", 1'b0, 1'b0, '0);
        tick();

        // An invalid ID slot never stalls.
        lw(5'd1, 5'd5);
        tick();
        drive(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("invalid_no_stall", 1'b0, 1'b0, bit_of(5));
        tick();

        // WAW: an ALU write to a register with a pending load stalls.
        lw(5'd2, 5'd13);
        tick();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("waw_stall", 1'b1, 1'b0, bit_of(13));
        tick();
        expect_out("waw_release", 1'b0, 1'b0, '0);
        tick();

        // Register 0 and ALU writers are never tracked.
        lw(5'd1, 5'd0);
        tick();
        alu(5'd0, 5'd0, 5'd3, 1'b0);
        expect_out("r0_no_stall", 1'b0, 1'b0, '0);
        tick();
        alu(5'd1, 5'd2, 5'd9, 1'b0);
        tick();
        alu(5'd9, 5'd9, 5'd4, 1'b0);
        expect_out("alu_no_stall", 1'b0, 1'b0, '0);
        tick();

        // Asynchronous reset in the middle of an MDU countdown.
        mdu(5'd1, 5'd2, 5'd8, 1'b1);
        tick();
        alu(5'd8, 5'd3, 5'd14, 1'b0);
        expect_out("pre_reset_cnt4", 1'b1, 1'b1, bit_of(8));
        tick();
        expect_out("pre_reset_cnt3", 1'b1, 1'b1, bit_of(8));
        tick();
        expect_out("pre_reset_cnt2", 1'b1, 1'b1, bit_of(8));
`ifdef SCOREBOARD_STATS_EN
        checks++;
        assert (stall_cycles === 32'(exp_stall_cnt)) else begin
            errors++;
            $error("FAIL stall_cycles_count: observed %0d expected %0d", stall_cycles, exp_stall_cnt);
        end
`endif
        rst_n = 1'b0;
        expect_out("async_reset", 1'b0, 1'b0, '0);
`ifdef SCOREBOARD_STATS_EN
        checks++;
        assert (stall_cycles === 32'd0) else begin
            errors++;
            $error("FAIL stall_cycles_reset: observed %0d expected 0", stall_cycles);
        end
`endif
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        last_exp_stall = 1'b0;
        tick();
        expect_out("post_reset_idle", 1'b0, 1'b0, '0);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
